tilelink_mem_arbiter_n: RTL and testbench

//  N-client uncached TileLink memory interconnect with one manager port.

---
 rtl/tilelink_mem_arbiter_n_if.sv | 74 +++++++
 rtl/tilelink_mem_arbiter_n.sv | 116 +++++++++++
 tb/tb_tilelink_mem_arbiter_n.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tilelink_mem_arbiter_n_if.sv
// Client-side and manager-side TileLink acquire/grant buses of the N-client arbiter.
// Per-client buses are packed [client][field], so client i sits at slice [i*W +: W].
interface tilelink_mem_arbiter_n_if #(
    parameter int N_CLIENTS = 4,
    parameter int CW        = 2,
    parameter int ID_W      = 2,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 64
);
    localparam int OID_W = ID_W + CW;

    // client acquire
    logic [N_CLIENTS-1:0]             in_acq_valid;
    logic [N_CLIENTS-1:0]             in_acq_ready;
    logic [N_CLIENTS-1:0][ADDR_W-1:0] in_acq_addr_block;
    logic [N_CLIENTS-1:0][ID_W-1:0]   in_acq_xact_id;
    logic [N_CLIENTS-1:0][2:0]        in_acq_addr_beat;
    logic [N_CLIENTS-1:0]             in_acq_builtin;
    logic [N_CLIENTS-1:0][2:0]        in_acq_a_type;
    logic [N_CLIENTS-1:0][11:0]       in_acq_union;
    logic [N_CLIENTS-1:0][DATA_W-1:0] in_acq_data;
    // client grant
    logic [N_CLIENTS-1:0]             in_gnt_ready;
    logic [N_CLIENTS-1:0]             in_gnt_valid;
    logic [N_CLIENTS-1:0][2:0]        in_gnt_addr_beat;
    logic [N_CLIENTS-1:0][ID_W-1:0]   in_gnt_xact_id;
    logic [N_CLIENTS-1:0]             in_gnt_mgr_xact_id;
    logic [N_CLIENTS-1:0]             in_gnt_builtin;
    logic [N_CLIENTS-1:0][3:0]        in_gnt_g_type;
    logic [N_CLIENTS-1:0][DATA_W-1:0] in_gnt_data;
    // manager acquire
    logic                             out_acq_ready;
    logic                             out_acq_valid;
    logic [ADDR_W-1:0]                out_acq_addr_block;
    logic [OID_W-1:0]                 out_acq_xact_id;
    logic [2:0]                       out_acq_addr_beat;
    logic                             out_acq_builtin;
    logic [2:0]                       out_acq_a_type;
    logic [11:0]                      out_acq_union;
    logic [DATA_W-1:0]                out_acq_data;
    // manager grant
    logic                             out_gnt_ready;
    logic                             out_gnt_valid;
    logic [2:0]                       out_gnt_addr_beat;
    logic [OID_W-1:0]                 out_gnt_xact_id;
    logic                             out_gnt_mgr_xact_id;
    logic                             out_gnt_builtin;
    logic [3:0]                       out_gnt_g_type;
    logic [DATA_W-1:0]                out_gnt_data;

    // arbiter side
    modport slave (
        input  in_acq_valid, in_acq_addr_block, in_acq_xact_id, in_acq_addr_beat,
               in_acq_builtin, in_acq_a_type, in_acq_union, in_acq_data, in_gnt_ready,
               out_acq_ready, out_gnt_valid, out_gnt_addr_beat, out_gnt_xact_id,
               out_gnt_mgr_xact_id, out_gnt_builtin, out_gnt_g_type, out_gnt_data,
        output in_acq_ready, in_gnt_valid, in_gnt_addr_beat, in_gnt_xact_id,
               in_gnt_mgr_xact_id, in_gnt_builtin, in_gnt_g_type, in_gnt_data,
               out_acq_valid, out_acq_addr_block, out_acq_xact_id, out_acq_addr_beat,
               out_acq_builtin, out_acq_a_type, out_acq_union, out_acq_data, out_gnt_ready
    );

    // clients plus memory side, seen from outside the arbiter
    modport master (
        output in_acq_valid, in_acq_addr_block, in_acq_xact_id, in_acq_addr_beat,
               in_acq_builtin, in_acq_a_type, in_acq_union, in_acq_data, in_gnt_ready,
               out_acq_ready, out_gnt_valid, out_gnt_addr_beat, out_gnt_xact_id,
               out_gnt_mgr_xact_id, out_gnt_builtin, out_gnt_g_type, out_gnt_data,
        input  in_acq_ready, in_gnt_valid, in_gnt_addr_beat, in_gnt_xact_id,
               in_gnt_mgr_xact_id, in_gnt_builtin, in_gnt_g_type, in_gnt_data,
               out_acq_valid, out_acq_addr_block, out_acq_xact_id, out_acq_addr_beat,
               out_acq_builtin, out_acq_a_type, out_acq_union, out_acq_data, out_gnt_ready
    );
endinterface

// File: rtl/tilelink_mem_arbiter_n.sv
// N-client uncached TileLink interconnect: round-robin acquire arbitration with a
// PutBlock burst lock, client index tagged into xact_id and used to route grants back.
module tilelink_mem_arbiter_n #(
    parameter int N_CLIENTS  = 4,
    parameter int CW         = (N_CLIENTS > 2) ? $clog2(N_CLIENTS) : 1,
    parameter int ID_W       = 2,
    parameter int ADDR_W     = 26,
    parameter int ADDR_SHIFT = 0,
    parameter int BEATS      = 8,
    parameter int DATA_W     = 64
) (
    input logic                     clk,
    input logic                     reset,
    tilelink_mem_arbiter_n_if.slave bus
);
    localparam int BCW = (BEATS > 2) ? $clog2(BEATS) : 1;

    typedef enum logic {S_OPEN, S_LOCKED} state_t;

    state_t         state;
    logic [CW-1:0]  rr_ptr, lock_id, winner, sel, dst;
    logic [BCW-1:0] beat_cnt;
    logic [CW:0]    cand;
    logic           lock, found, fire, put_block, gnt_in_range;

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
        return (int'(i) == N_CLIENTS - 1) ? '0 : i + 1'b1;
    endfunction

    // first valid client at or after rr_ptr, wrapping modulo N_CLIENTS
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 0; k < N_CLIENTS; k++) begin
            cand = {1'b0, rr_ptr} + (CW+1)'(k);
            if (int'(cand) >= N_CLIENTS) cand = cand - (CW+1)'(N_CLIENTS);
            if (!found && bus.in_acq_valid[cand[CW-1:0]]) begin
                winner = cand[CW-1:0];
                found  = 1'b1;
            end
        end
    end

    assign lock      = (state == S_LOCKED);
    assign sel       = lock ? lock_id : winner;
    assign fire      = bus.out_acq_valid & bus.out_acq_ready;
    assign put_block = bus.in_acq_builtin[sel] && (bus.in_acq_a_type[sel] == 3'h3);

    // handshakes are held off while reset is asserted so nothing fires into a cleared lock
    assign bus.out_acq_valid = reset & (lock ? bus.in_acq_valid[lock_id] : found);

    always_comb begin
        bus.in_acq_ready = '0;
        if (reset && (lock || found)) bus.in_acq_ready[sel] = bus.out_acq_ready;
    end

    assign bus.out_acq_addr_block = bus.in_acq_addr_block[sel] >> ADDR_SHIFT;
    assign bus.out_acq_xact_id    = {bus.in_acq_xact_id[sel], sel};
    assign bus.out_acq_addr_beat  = bus.in_acq_addr_beat[sel];
    assign bus.out_acq_builtin    = bus.in_acq_builtin[sel];
    assign bus.out_acq_a_type     = bus.in_acq_a_type[sel];
    assign bus.out_acq_union      = bus.in_acq_union[sel];
    assign bus.out_acq_data       = bus.in_acq_data[sel];

    // rr_ptr only moves when a single-beat acquire or a whole burst completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_OPEN;
            rr_ptr   <= '0;
            lock_id  <= '0;
            beat_cnt <= '0;
        end else if (fire) begin
            case (state)
                S_OPEN: begin
                    if (put_block) begin
                        state    <= S_LOCKED;
                        lock_id  <= winner;
                        beat_cnt <= BCW'(1);
                    end else begin
                        rr_ptr <= next_idx(winner);
                    end
                end
                S_LOCKED: begin
                    if (int'(beat_cnt) == BEATS - 1) begin
                        state    <= S_OPEN;
                        beat_cnt <= '0;
                        rr_ptr   <= next_idx(lock_id);
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: state <= S_OPEN;
            endcase
        end
    end

    // an out-of-range tag is swallowed so a bad grant cannot wedge the manager
    assign dst          = bus.out_gnt_xact_id[CW-1:0];
    assign gnt_in_range = int'(dst) < N_CLIENTS;
    assign bus.out_gnt_ready = reset & (gnt_in_range ? bus.in_gnt_ready[dst] : 1'b1);

    always_comb begin
        bus.in_gnt_valid = '0;
        if (reset && gnt_in_range) bus.in_gnt_valid[dst] = bus.out_gnt_valid;
    end

    for (genvar i = 0; i < N_CLIENTS; i++) begin : g_gnt_fanout
        assign bus.in_gnt_addr_beat[i]   = bus.out_gnt_addr_beat;
        assign bus.in_gnt_xact_id[i]     = bus.out_gnt_xact_id[ID_W+CW-1:CW];
        assign bus.in_gnt_mgr_xact_id[i] = bus.out_gnt_mgr_xact_id;
        assign bus.in_gnt_builtin[i]     = bus.out_gnt_builtin;
        assign bus.in_gnt_g_type[i]      = bus.out_gnt_g_type;
        assign bus.in_gnt_data[i]        = bus.out_gnt_data;
    end
endmodule

// File: tb/tb_tilelink_mem_arbiter_n.sv
// Self-checking bench for tilelink_mem_arbiter_n: directed scenarios plus a randomized
// run compared against a round-robin / burst-lock reference model kept in the bench.
module tb_tilelink_mem_arbiter_n;
    localparam int N = 4, CW = 2, ID_W = 2, ADDR_W = 26, SHIFT = 2, BEATS = 8, DATA_W = 64;
    localparam int FW = ID_W + CW + ADDR_W + 3 + 1 + 3 + 12 + DATA_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    tilelink_mem_arbiter_n_if #(.N_CLIENTS(N), .CW(CW), .ID_W(ID_W), .ADDR_W(ADDR_W),
                                .DATA_W(DATA_W)) bus ();

    tilelink_mem_arbiter_n #(.N_CLIENTS(N), .CW(CW), .ID_W(ID_W), .ADDR_W(ADDR_W),
                             .ADDR_SHIFT(SHIFT), .BEATS(BEATS), .DATA_W(DATA_W))
        dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0, errors = 0;

    // client stimulus
    logic [N-1:0]      c_valid, c_builtin;
    logic [ADDR_W-1:0] c_addr [N];
    logic [ID_W-1:0]   c_id   [N];
    logic [2:0]        c_beat [N];
    logic [2:0]        c_type [N];
    logic [11:0]       c_union[N];
    logic [DATA_W-1:0] c_data [N];
    logic              m_acq_ready;

    // reference model: plain integers for pointer, lock owner and beats taken
    int m_rr, m_lock_id, m_beats;
    bit m_locked;
    int e_sel;
    bit e_valid;
    logic [N-1:0] e_ready;

    always @(negedge clk)
        if (reset && bus.out_gnt_valid)
            assert (int'(bus.out_gnt_xact_id[CW-1:0]) < N) else $error("grant tag out of range");

    task automatic model_clear();
        m_rr = 0; m_lock_id = 0; m_beats = 0; m_locked = 0;
    endtask

    task automatic model_eval();
        e_sel = -1; e_valid = 0; e_ready = '0;
        if (reset) begin
            if (m_locked) begin
                e_sel = m_lock_id;
                e_valid = c_valid[m_lock_id];
            end else begin
                for (int k = 0; k < N; k++)
                    if (e_sel < 0 && c_valid[(m_rr + k) % N]) e_sel = (m_rr + k) % N;
                e_valid = (e_sel >= 0);
            end
            if (e_sel >= 0) e_ready[e_sel] = m_acq_ready;
        end
    endtask

    task automatic model_commit();
        model_eval();
        if (!reset) model_clear();
        else if (e_valid && m_acq_ready) begin
            if (!m_locked) begin
                if (c_builtin[e_sel] && c_type[e_sel] == 3'h3) begin
                    m_locked = 1; m_lock_id = e_sel; m_beats = 1;
                end else m_rr = (e_sel + 1) % N;
            end else begin
                m_beats++;
                if (m_beats == BEATS) begin
                    m_locked = 0; m_beats = 0; m_rr = (m_lock_id + 1) % N;
                end
            end
        end
    endtask

    task automatic drive();
        bus.in_acq_valid   = c_valid;
        bus.in_acq_builtin = c_builtin;
        for (int i = 0; i < N; i++) begin
            bus.in_acq_addr_block[i] = c_addr[i];
            bus.in_acq_xact_id[i]    = c_id[i];
            bus.in_acq_addr_beat[i]  = c_beat[i];
            bus.in_acq_a_type[i]     = c_type[i];
            bus.in_acq_union[i]      = c_union[i];
            bus.in_acq_data[i]       = c_data[i];
        end
        bus.out_acq_ready = m_acq_ready;
    endtask

    task automatic settle();
        drive();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic rand_fields(input int i, input bit put);
        int t;
        c_addr[i]  = ADDR_W'($urandom);
        c_id[i]    = ID_W'($urandom);
        c_beat[i]  = 3'($urandom);
        c_union[i] = 12'($urandom);
        c_data[i]  = {$urandom, $urandom};
        t = $urandom_range(0, 6);
        if (t >= 3) t++;
        c_builtin[i] = put ? 1'b1 : 1'($urandom);
        c_type[i]    = put ? 3'h3 : 3'(t);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        c_valid = '1;
        m_acq_ready = 1'b1;
        for (int i = 0; i < N; i++) rand_fields(i, 0);
        for (int c = 0; c < 2; c++) begin
            settle();
            checks++;
            if (bus.in_acq_ready !== '0) begin
                errors++; $display("FAIL reset_acq_ready got %b expected %b", bus.in_acq_ready, 4'b0);
            end
            checks++;
            if (bus.out_acq_valid !== 1'b0) begin
                errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_acq_valid);
            end
            tick();
        end
        reset = 1'b1;
        settle();
        checks++;
        if (bus.in_acq_ready !== 4'b0001 || bus.out_acq_xact_id[CW-1:0] !== 2'd0) begin
            errors++;
            $display("FAIL reset_first_winner got ready %b tag %0d expected ready 0001 tag 0",
                     bus.in_acq_ready, bus.out_acq_xact_id[CW-1:0]);
        end
    endtask

    task automatic test_rr_fairness();
        int exp_w;
        c_valid = '1;
        m_acq_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            for (int i = 0; i < N; i++) rand_fields(i, 0);
            exp_w = j % N;
            settle();
            checks++;
            if (bus.in_acq_ready !== 4'(1 << exp_w)) begin
                errors++; $display("FAIL rr_winner[%0d] got %b expected client %0d", j, bus.in_acq_ready, exp_w);
            end
            checks++;
            if (bus.out_acq_xact_id !== {c_id[exp_w], CW'(exp_w)}) begin
                errors++; $display("FAIL rr_xact_id[%0d] got %h expected %h", j, bus.out_acq_xact_id,
                                   {c_id[exp_w], CW'(exp_w)});
            end
            tick();
        end
    endtask

    task automatic test_lock();
        int beats = 0;
        // one fire from client 1 alone moves the pointer onto client 2
        c_valid = 4'b0010;
        rand_fields(1, 0);
        m_acq_ready = 1'b1;
        settle();
        tick();
        c_valid = 4'b0110;
        rand_fields(2, 1);
        for (int cyc = 0; cyc < 40 && beats < BEATS; cyc++) begin
            m_acq_ready = (cyc % 2 == 0);
            c_beat[2] = 3'(beats);
            c_data[2] = {$urandom, $urandom};
            settle();
            checks++;
            if (bus.in_acq_ready[1] !== 1'b0) begin
                errors++; $display("FAIL lock_intruder cyc %0d got ready1 %b expected 0", cyc, bus.in_acq_ready[1]);
            end
            if (bus.out_acq_valid && m_acq_ready) begin
                checks++;
                if (bus.out_acq_xact_id[CW-1:0] !== 2'd2 || bus.out_acq_data !== c_data[2]) begin
                    errors++; $display("FAIL lock_beat %0d got tag %0d expected tag 2", beats,
                                       bus.out_acq_xact_id[CW-1:0]);
                end
                beats++;
            end
            tick();
        end
        checks++;
        if (beats != BEATS) begin
            errors++; $display("FAIL lock_beat_count got %0d expected %0d", beats, BEATS);
        end
        // pointer should now sit on client 3
        c_valid = 4'b1111;
        rand_fields(2, 0);
        m_acq_ready = 1'b1;
        settle();
        checks++;
        if (bus.in_acq_ready !== 4'b1000) begin
            errors++; $display("FAIL lock_rr_after got %b expected 1000", bus.in_acq_ready);
        end
        c_valid = 4'b0110;
        settle();
        checks++;
        if (bus.in_acq_ready !== 4'b0010) begin
            errors++; $display("FAIL lock_next_client got %b expected 0010", bus.in_acq_ready);
        end
        tick();
    endtask

    task automatic test_grant_routing();
        c_valid = '0;
        m_acq_ready = 1'b0;
        drive();
        bus.out_gnt_valid   = 1'b1;
        bus.out_gnt_xact_id = {2'b10, 2'd3};
        bus.out_gnt_data    = 64'hDEAD_BEEF_0123_4567;
        bus.out_gnt_g_type  = 4'h5;
        bus.in_gnt_ready    = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) bus.in_gnt_ready = 4'b1000;
            #1;
            checks++;
            if (bus.in_gnt_valid !== 4'b1000 || bus.in_gnt_xact_id[3] !== 2'b10) begin
                errors++; $display("FAIL gnt_route c%0d got valid %b id %b expected 1000 id 10",
                                   c, bus.in_gnt_valid, bus.in_gnt_xact_id[3]);
            end
            checks++;
            if (bus.out_gnt_ready !== (c == 2)) begin
                errors++; $display("FAIL gnt_ready c%0d got %b expected %b", c, bus.out_gnt_ready, c == 2);
            end
            tick();
        end
        bus.out_gnt_valid = 1'b0;
        bus.in_gnt_ready  = '0;
    endtask

    task automatic test_reset_mid_burst();
        c_valid = 4'b0001;
        rand_fields(0, 1);
        m_acq_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            settle();
            tick();
        end
        reset = 1'b0;
        settle();
        checks++;
        if (bus.out_acq_valid !== 1'b0) begin
            errors++; $display("FAIL midburst_reset_valid got %b expected 0", bus.out_acq_valid);
        end
        tick();
        reset = 1'b1;
        c_valid = 4'b1010;
        rand_fields(1, 0);
        rand_fields(3, 0);
        settle();
        checks++;
        if (bus.out_acq_valid !== 1'b1 || bus.in_acq_ready !== 4'b0010) begin
            errors++; $display("FAIL midburst_unlock got valid %b ready %b expected 1 0010",
                               bus.out_acq_valid, bus.in_acq_ready);
        end
        tick();
    endtask

    task automatic test_addr_shift();
        c_valid = 4'b0001;
        rand_fields(0, 0);
        c_addr[0] = 26'h00000F0;
        m_acq_ready = 1'b1;
        settle();
        checks++;
        if (bus.out_acq_addr_block !== 26'h000003C) begin
            errors++; $display("FAIL addr_shift got %h expected %h", bus.out_acq_addr_block, 26'h3C);
        end
        tick();
    endtask

    task automatic test_random();
        logic [FW-1:0] exp_f, got_f;
        logic [ID_W-1:0] gid;
        int dst, k;
        bit gv;
        for (int cyc = 0; cyc < 400; cyc++) begin
            c_valid = N'($urandom);
            if (m_locked && $urandom_range(0, 3) != 0) c_valid[m_lock_id] = 1'b1;
            for (int i = 0; i < N; i++) begin
                rand_fields(i, 0);
                if ($urandom_range(0, 4) == 0) begin
                    c_builtin[i] = 1'($urandom_range(0, 3) != 0);
                    c_type[i] = 3'h3;
                end
            end
            m_acq_ready = 1'($urandom);
            gv  = 1'($urandom);
            dst = $urandom_range(0, N - 1);
            gid = ID_W'($urandom);
            bus.out_gnt_valid       = gv;
            bus.out_gnt_xact_id     = {gid, CW'(dst)};
            bus.out_gnt_data        = {$urandom, $urandom};
            bus.out_gnt_addr_beat   = 3'($urandom);
            bus.out_gnt_mgr_xact_id = 1'($urandom);
            bus.out_gnt_builtin     = 1'($urandom);
            bus.out_gnt_g_type      = 4'($urandom);
            bus.in_gnt_ready        = N'($urandom);
            settle();
            checks++;
            if (bus.out_acq_valid !== e_valid || bus.in_acq_ready !== e_ready) begin
                errors++; $display("FAIL rand_acq cyc %0d got valid %b ready %b expected %b %b",
                                   cyc, bus.out_acq_valid, bus.in_acq_ready, e_valid, e_ready);
            end
            if (e_sel >= 0) begin
                exp_f = {c_id[e_sel], CW'(e_sel), c_addr[e_sel] >> SHIFT, c_beat[e_sel],
                         c_builtin[e_sel], c_type[e_sel], c_union[e_sel], c_data[e_sel]};
                got_f = {bus.out_acq_xact_id, bus.out_acq_addr_block, bus.out_acq_addr_beat,
                         bus.out_acq_builtin, bus.out_acq_a_type, bus.out_acq_union, bus.out_acq_data};
                checks++;
                if (got_f !== exp_f) begin
                    errors++; $display("FAIL rand_fields cyc %0d got %h expected %h", cyc, got_f, exp_f);
                end
            end
            checks++;
            if (bus.in_gnt_valid !== (gv ? 4'(1 << dst) : 4'b0) ||
                bus.out_gnt_ready !== bus.in_gnt_ready[dst]) begin
                errors++; $display("FAIL rand_gnt cyc %0d got valid %b ready %b dst %0d", cyc,
                                   bus.in_gnt_valid, bus.out_gnt_ready, dst);
            end
            k = $urandom_range(0, N - 1);
            checks++;
            if (bus.in_gnt_data[k] !== bus.out_gnt_data || bus.in_gnt_xact_id[k] !== gid) begin
                errors++; $display("FAIL rand_gnt_fanout cyc %0d client %0d got id %b expected %b",
                                   cyc, k, bus.in_gnt_xact_id[k], gid);
            end
            tick();
        end
        bus.out_gnt_valid = 1'b0;
    endtask

    initial begin
        c_valid = '0;
        c_builtin = '0;
        m_acq_ready = 1'b0;
        for (int i = 0; i < N; i++) rand_fields(i, 0);
        bus.in_gnt_ready        = '0;
        bus.out_gnt_valid       = 1'b0;
        bus.out_gnt_addr_beat   = '0;
        bus.out_gnt_xact_id     = '0;
        bus.out_gnt_mgr_xact_id = 1'b0;
        bus.out_gnt_builtin     = 1'b0;
        bus.out_gnt_g_type      = '0;
        bus.out_gnt_data        = '0;
        drive();
        model_clear();
        test_reset();
        test_rr_fairness();
        test_lock();
        test_grant_routing();
        test_reset_mid_burst();
        test_addr_shift();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
